// File: rtl/seq_addsub.sv
// Chunk-serial adder/subtractor: adds CHUNK bits per clock over WIDTH/CHUNK cycles,
// then publishes sum and flags together with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; last result and flags held on outputs
// RUN   | adding one chunk per clock; outputs still show previous result
module seq_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int N  = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("seq_addsub: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             done_q, done_d;

  logic [CHUNK:0]   chunk_full;
  logic [WIDTH-1:0] chunk_ext;
  logic [WIDTH-1:0] acc_next;

  // Operands shift right one chunk per clock; the result fills in from the top.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    done_d  = 1'b0;

    chunk_full = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(carry_q);
    chunk_ext  = '0;
    chunk_ext[CHUNK-1:0] = chunk_full[CHUNK-1:0];
    acc_next   = (acc_q >> CHUNK) | (chunk_ext << (WIDTH - CHUNK));

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = chunk_full[CHUNK];
        acc_d   = acc_next;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
          sum_d   = acc_next;
          cout_d  = chunk_full[CHUNK];
          // carry into the MSB recovered as a ^ b ^ sum at that bit
          ovf_d   = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_full[CHUNK-1] ^ chunk_full[CHUNK];
          zero_d  = (acc_next == '0);
          neg_d   = acc_next[WIDTH-1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
  assign neg  = neg_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub: directed corner cases, randomized ops against an arithmetic
// reference, reset abort, back-to-back starts and two parameter variants.
module tb_seq_addsub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default 16/4 instance
  logic        start16, sub16, cin16;
  logic [15:0] a16, b16;
  logic        busy16, done16, cout16, ovf16, zero16, neg16;
  logic [15:0] sum16;

  // single-chunk 16/16 instance
  logic        start1, sub1, cin1;
  logic [15:0] a1, b1;
  logic        busy1, done1, cout1, ovf1, zero1, neg1;
  logic [15:0] sum1;

  // 32/8 instance
  logic        start32, sub32, cin32;
  logic [31:0] a32, b32;
  logic        busy32, done32, cout32, ovf32, zero32, neg32;
  logic [31:0] sum32;

  seq_addsub #(.WIDTH(16), .CHUNK(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16),
    .zero(zero16), .neg(neg16)
  );

  seq_addsub #(.WIDTH(16), .CHUNK(16)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1),
    .zero(zero1), .neg(neg1)
  );

  seq_addsub #(.WIDTH(32), .CHUNK(8)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .sub(sub32), .a(a32), .b(b32), .cin(cin32),
    .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .ovf(ovf32),
    .zero(zero32), .neg(neg32)
  );

  int tests = 0;
  int fails = 0;
  logic [15:0] prev_sum;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's definition.
  function automatic void model16(input logic [15:0] a, input logic [15:0] b,
                                  input logic s, input logic c,
                                  output logic [15:0] r, output logic co,
                                  output logic ov, output logic z, output logic n);
    int ua, ub, sa, sb, ures, sres;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      ures = ua - ub;
      sres = sa - sb;
      co   = (ua >= ub);
    end else begin
      ures = ua + ub + int'(c);
      sres = sa + sb + int'(c);
      co   = (ures > 65535);
    end
    r  = 16'(ures);
    ov = (sres > 32767) || (sres < -32768);
    z  = (r == 16'h0000);
    n  = r[15];
  endfunction

  task automatic op16(input logic [15:0] a, input logic [15:0] b,
                      input logic s, input logic c, input bit noise);
    logic [15:0] er;
    logic eco, eov, ez, en;
    int cyc;
    model16(a, b, s, c, er, eco, eov, ez, en);
    a16 = a; b16 = b; sub16 = s; cin16 = c; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    cyc = 0;
    check("busy_after_start", {31'd0, busy16}, 32'd1);
    while (!done16 && cyc < 20) begin
      check("sum_hold_in_run", {16'd0, sum16}, {16'd0, prev_sum});
      if (noise) begin
        a16 = 16'($urandom); b16 = 16'($urandom);
        sub16 = 1'($urandom); cin16 = 1'($urandom); start16 = 1'($urandom);
      end
      tick();
      cyc++;
    end
    start16 = 1'b0;
    check("latency16", cyc, 32'd4);
    check("sum16",  {16'd0, sum16}, {16'd0, er});
    check("cout16", {31'd0, cout16}, {31'd0, eco});
    check("ovf16",  {31'd0, ovf16},  {31'd0, eov});
    check("zero16", {31'd0, zero16}, {31'd0, ez});
    check("neg16",  {31'd0, neg16},  {31'd0, en});
    check("busy_at_done", {31'd0, busy16}, 32'd0);
    prev_sum = er;
  endtask

  initial begin
    int cyc, ndone;
    rst = 1'b1;
    start16 = 0; sub16 = 0; cin16 = 0; a16 = '0; b16 = '0;
    start1 = 0; sub1 = 0; cin1 = 0; a1 = '0; b1 = '0;
    start32 = 0; sub32 = 0; cin32 = 0; a32 = '0; b32 = '0;
    prev_sum = 16'h0000;
    tick(); tick();
    rst = 1'b0;

    check("rst_busy", {31'd0, busy16}, 32'd0);
    check("rst_done", {31'd0, done16}, 32'd0);
    check("rst_sum",  {16'd0, sum16}, 32'd0);
    check("rst_flags", {28'd0, cout16, ovf16, zero16, neg16}, 32'd0);

    // directed corners
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    op16(16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0);
    check("cin_add_sum", {16'd0, sum16}, 32'h1235);
    op16(16'h0003, 16'h0005, 1'b1, 1'b0, 1'b0);
    check("sub_neg_sum", {16'd0, sum16}, 32'hFFFE);
    op16(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0);
    check("sub_ovf_sum", {16'd0, sum16}, 32'h7FFF);
    tick();
    check("done_one_cycle", {31'd0, done16}, 32'd0);
    check("sum_held_idle", {16'd0, sum16}, {16'd0, prev_sum});

    // start while busy is ignored; back-to-back start in the done cycle
    a16 = 16'h1111; b16 = 16'h2222; sub16 = 0; cin16 = 0; start16 = 1;
    tick(); start16 = 0;
    tick();
    a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1;
    tick(); start16 = 0;
    check("no_early_done_a", {31'd0, done16}, 32'd0);
    tick();
    check("no_early_done_b", {31'd0, done16}, 32'd0);
    tick();
    check("busy_ignore_done", {31'd0, done16}, 32'd1);
    check("busy_ignore_sum", {16'd0, sum16}, 32'h3333);
    prev_sum = 16'h3333;
    op16(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
    check("b2b_sum", {16'd0, sum16}, 32'h0002);

    // reset aborts an operation in flight
    tick();
    a16 = 16'h1234; b16 = 16'h4321; start16 = 1;
    tick(); start16 = 0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {31'd0, busy16}, 32'd0);
    check("abort_sum", {16'd0, sum16}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      if (done16) ndone++;
      tick();
    end
    check("abort_no_done", ndone, 32'd0);
    prev_sum = 16'h0000;
    op16(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
    check("post_rst_sum", {16'd0, sum16}, 32'h0100);

    // randomized ops with input noise and spurious starts during RUN
    for (int i = 0; i < 40; i++) begin
      op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) tick();
    end

    // single-chunk variant
    a1 = 16'hFFFF; b1 = 16'h0001; start1 = 1;
    tick(); start1 = 0;
    cyc = 0;
    while (!done1 && cyc < 10) begin tick(); cyc++; end
    check("w16c16_latency", cyc, 32'd1);
    check("w16c16_sum", {16'd0, sum1}, 32'd0);
    check("w16c16_cout", {31'd0, cout1}, 32'd1);
    check("w16c16_zero", {31'd0, zero1}, 32'd1);

    // 32-bit, 8-bit chunk variant
    a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; start32 = 1;
    tick(); start32 = 0;
    cyc = 0;
    while (!done32 && cyc < 20) begin tick(); cyc++; end
    check("w32c8_latency", cyc, 32'd4);
    check("w32c8_sum", sum32, 32'd0);
    check("w32c8_cout", {31'd0, cout32}, 32'd1);
    check("w32c8_zero", {31'd0, zero32}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
